// File: rtl/capture_scan.sv
//==============================================================================
// Module      : capture_scan
// Description : Steps the antenna select through every antenna, collects the
//               lock/phase outcome of each, and serves it on a read port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module capture_scan #(
    parameter int AXNUM  = 24,
    parameter int SBITS  = 5,
    parameter int PBITS  = 4,
    parameter int SETTLE = 4,
    parameter int HOLD   = 3,
    parameter int BLANK  = 8,
    parameter int TBITS  = 12
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [SBITS-1:0]   select_o,
    output logic               restart_o,
    input  logic               locked_i,
    input  logic               invalid_i,
    input  logic [PBITS-1:0]   phase_i,
    input  logic [SBITS-1:0]   raddr_i,
    output logic [PBITS+1:0]   rdata_o,
    output logic [SBITS:0]     nlock_o
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_select  = 3'd1;
    localparam logic [2:0] c_st_restart = 3'd2;
    localparam logic [2:0] c_st_wait    = 3'd3;
    localparam logic [2:0] c_st_store   = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    localparam logic [TBITS-1:0] c_cnt_max     = '1;
    localparam logic [TBITS-1:0] c_cnt_one     = 1;
    localparam logic [TBITS-1:0] c_settle_last = TBITS'(SETTLE - 1);
    localparam logic [TBITS-1:0] c_hold_last   = TBITS'(HOLD - 1);
    localparam logic [TBITS-1:0] c_blank       = TBITS'(BLANK);
    localparam logic [SBITS-1:0] c_idx_last    = SBITS'(AXNUM - 1);
    localparam logic [SBITS-1:0] c_idx_one     = 1;
    localparam logic [SBITS:0]   c_nlock_one   = 1;

    logic [2:0]       state_q, state_d;
    logic [TBITS-1:0] cnt_q,   cnt_d;
    logic [SBITS-1:0] idx_q,   idx_d;
    logic [SBITS:0]   nlock_q, nlock_d;
    logic             fail_q,  fail_d;
    logic             lock_q,  lock_d;
    logic [PBITS-1:0] phase_q, phase_d;
    logic [PBITS+1:0] rdata_q, rdata_d;
    logic [PBITS+1:0] tbl_q [AXNUM];
    logic [PBITS+1:0] tbl_d [AXNUM];
    logic             w_wr_en;
    logic             w_sample;

    assign w_sample = (cnt_q >= c_blank);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nlock_d = nlock_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        phase_d = phase_q;
        w_wr_en = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (start_i && !abort_i) begin
                    state_d = c_st_select;
                    cnt_d   = '0;
                    idx_d   = '0;
                    nlock_d = '0;
                end
            end
            c_st_select: begin
                if (cnt_q == c_settle_last) begin
                    state_d = c_st_restart;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            c_st_restart: begin
                if (cnt_q == c_hold_last) begin
                    state_d = c_st_wait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            c_st_wait: begin
                // Loss of lock outranks a lock seen in the same cycle.
                if (w_sample && invalid_i) begin
                    fail_d  = 1'b1;
                    lock_d  = 1'b0;
                    phase_d = '0;
                    state_d = c_st_store;
                end else if (w_sample && locked_i) begin
                    fail_d  = 1'b0;
                    lock_d  = 1'b1;
                    phase_d = phase_i;
                    state_d = c_st_store;
                end else if (cnt_q == c_cnt_max) begin
                    fail_d  = 1'b1;
                    lock_d  = 1'b0;
                    phase_d = '0;
                    state_d = c_st_store;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            c_st_store: begin
                w_wr_en = 1'b1;
                cnt_d   = '0;
                if (lock_q) begin
                    nlock_d = nlock_q + c_nlock_one;
                end
                if (idx_q == c_idx_last) begin
                    state_d = c_st_done;
                end else begin
                    idx_d   = idx_q + c_idx_one;
                    state_d = c_st_select;
                end
            end
            c_st_done: begin
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // Abort discards whatever this cycle would have committed.
        if (abort_i && (state_q != c_st_idle)) begin
            state_d = c_st_idle;
            cnt_d   = '0;
            idx_d   = idx_q;
            nlock_d = nlock_q;
            w_wr_en = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < AXNUM; i++) begin
            tbl_d[i] = tbl_q[i];
            if (w_wr_en && (idx_q == SBITS'(i))) begin
                tbl_d[i] = {fail_q, lock_q, phase_q};
            end
        end
    end

    // Addresses past the last antenna fall through to zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < AXNUM; i++) begin
            if (raddr_i == SBITS'(i)) begin
                rdata_d = tbl_q[i];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            nlock_q <= '0;
            fail_q  <= 1'b0;
            lock_q  <= 1'b0;
            phase_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < AXNUM; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nlock_q <= nlock_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
            phase_q <= phase_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < AXNUM; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    assign busy_o    = (state_q != c_st_idle);
    assign done_o    = (state_q == c_st_done);
    assign restart_o = (state_q == c_st_restart);
    assign select_o  = idx_q;
    assign rdata_o   = rdata_q;
    assign nlock_o   = nlock_q;

endmodule

`default_nettype wire
